operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 23 ++
 rtl/operand_fetch_regfile.sv | 33 +++
 rtl/operand_fetch.sv | 134 +++++++++++++
 tb/tb_operand_fetch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand fetch stage: FSM states,
// default datapath width, register index width and shift codes.
package operand_fetch_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int IDX_W      = 3;

    // Shift codes carried alongside the operands to the shifter.
    localparam logic [1:0] SHIFT_NONE = 2'b00;
    localparam logic [1:0] SHIFT_LSL1 = 2'b01;
    localparam logic [1:0] SHIFT_LSR1 = 2'b10;
    localparam logic [1:0] SHIFT_ASR1 = 2'b11;

    // IDLE: accept a request; READ_A/READ_B: one register read each;
    // HOLD: present the bundle until downstream takes it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/operand_fetch_regfile.sv
// General register file: one synchronous write port, one asynchronous
// read port. Forwarding of same-cycle writes is handled by the caller.
module regfile
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [IDX_W-1:0]  writenum,
    input  logic [DATA_W-1:0] data_in,
    input  logic [IDX_W-1:0]  readnum,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] regs [NREG];

    // Reset clears every register and wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (write) begin
            regs[writenum] <= data_in;
        end
    end

    assign data_out = regs[readnum];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts a {rn, rm, shift} request, reads the two
// source registers over two cycles through a single read port, and holds
// the operand bundle until the shifter/ALU stage takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both 1. The request side is ready only in IDLE; the output side
// keeps out_valid and the bundle stable until out_ready is seen.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [2:0]        writenum,
    input  logic [DATA_W-1:0] data_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        rn,
    input  logic [2:0]        rm,
    input  logic [1:0]        shift_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ain,
    output logic [DATA_W-1:0] bin,
    output logic [1:0]        shift,
    output logic [1:0]        dbg_state
);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              load_a;
    logic              load_b;
    logic [2:0]        rn_q;
    logic [2:0]        rm_q;
    logic [1:0]        shift_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [2:0]        read_idx;
    logic [DATA_W-1:0] rf_data;
    logic [DATA_W-1:0] read_val;

    regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .writenum (writenum),
        .data_in  (data_in),
        .readnum  (read_idx),
        .data_out (rf_data)
    );

    // The single read port serves rn in READ_A and rm otherwise; a write
    // to the register being read this cycle is forwarded so the operand
    // sees the value that lands on this edge.
    assign read_idx = (state == READ_A) ? rn_q : rm_q;
    assign read_val = (write && (writenum == read_idx)) ? data_in : rf_data;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, handshake outputs and datapath load enables.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        load_a     = 1'b0;
        load_b     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = READ_A;
                end
            end
            READ_A: begin
                load_a     = 1'b1;
                state_next = READ_B;
            end
            READ_B: begin
                load_b     = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch and operand registers; nothing changes while held,
    // so later writes to a source register leave the bundle untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            rn_q    <= '0;
            rm_q    <= '0;
            shift_q <= SHIFT_NONE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            if (accept) begin
                rn_q    <= rn;
                rm_q    <= rm;
                shift_q <= shift_in;
            end
            if (load_a) begin
                a_q <= read_val;
            end
            if (load_b) begin
                b_q <= read_val;
            end
        end
    end

    assign ain       = a_q;
    assign bin       = b_q;
    assign shift     = shift_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, hand-written reset
// abort sequence, then randomized traffic against a reference model.
module tb_operand_fetch;

    localparam int DATA_W = 16;

    typedef struct {
        logic [2:0]  rn;
        logic [2:0]  rm;
        logic [1:0]  sh;
        int          hold;      // cycles with out_ready=0 in HOLD
        int          wr_phase;  // 0 none, 1 READ_A, 2 READ_B, 3 first HOLD cycle
        logic [2:0]  wr_idx;
        logic [15:0] wr_dat;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    // Clock and reset block
    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              write = 1'b0;
    logic [2:0]        writenum = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        rn = '0;
    logic [2:0]        rm = '0;
    logic [1:0]        shift_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] ain;
    logic [DATA_W-1:0] bin;
    logic [1:0]        shift;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    operand_fetch #(.DATA_W(DATA_W), .NREG(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .write     (write),
        .writenum  (writenum),
        .data_in   (data_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rn        (rn),
        .rm        (rm),
        .shift_in  (shift_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ain       (ain),
        .bin       (bin),
        .shift     (shift),
        .dbg_state (dbg_state)
    );

    // Reference register contents, updated at every edge from the inputs.
    logic [15:0] model_regs [8];
    int checks = 0;
    int errors = 0;

    // Scoreboard: expected {ain, bin, shift} bundles awaiting handshake.
    logic [33:0] exp_q[$];

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge; the model applies reset/write exactly as the
    // register file contract states, then outputs settle for sampling.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 8; i++) model_regs[i] = '0;
        end else if (write) begin
            model_regs[writenum] = data_in;
        end
        #1;
    endtask

    // Driver tasks
    task automatic do_write(input logic [2:0] idx, input logic [15:0] val);
        write = 1'b1; writenum = idx; data_in = val;
        step();
        write = 1'b0;
    endtask

    task automatic phase_write(input vec_t v, input int phase);
        if (v.wr_phase == phase) begin
            write = 1'b1; writenum = v.wr_idx; data_in = v.wr_dat;
        end
    endtask

    task automatic fetch(input vec_t v, input string tag);
        int guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 8) begin
            step();
            guard++;
        end
        check({tag, " req_ready idle"}, 34'(req_ready), 34'd1);
        req_valid = 1'b1; rn = v.rn; rm = v.rm; shift_in = v.sh;
        step();
        req_valid = 1'b0;
        rn = 3'($urandom_range(0, 7));
        rm = 3'($urandom_range(0, 7));
        shift_in = 2'($urandom_range(0, 3));
        check({tag, " out_valid c1"}, 34'(out_valid), 34'd0);
        check({tag, " req_ready c1"}, 34'(req_ready), 34'd0);
        phase_write(v, 1);
        step();
        write = 1'b0;
        check({tag, " out_valid c2"}, 34'(out_valid), 34'd0);
        phase_write(v, 2);
        step();
        write = 1'b0;
        for (int k = 0; k <= v.hold; k++) begin
            check({tag, " out_valid hold"}, 34'(out_valid), 34'd1);
            check({tag, " ain"}, 34'(ain), 34'(v.exp_a));
            check({tag, " bin"}, 34'(bin), 34'(v.exp_b));
            check({tag, " shift"}, 34'(shift), 34'(v.sh));
            if (k < v.hold) begin
                out_ready = 1'b0;
                if (k == 0) phase_write(v, 3);
                step();
                write = 1'b0;
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 34'(out_valid), 34'd0);
        check({tag, " req_ready back"}, 34'(req_ready), 34'd1);
    endtask

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        busy;
        int          n;
        logic [2:0]  crn, crm;
        logic [1:0]  csh;
        logic [15:0] ca;
        logic        exp_ov;

        for (int i = 0; i < 8; i++) model_regs[i] = 16'hXXXX;

        // Reset state
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset req_ready", 34'(req_ready), 34'd1);
        check("reset out_valid", 34'(out_valid), 34'd0);
        check("reset ain", 34'(ain), 34'd0);
        check("reset bin", 34'(bin), 34'd0);
        check("reset shift", 34'(shift), 34'd0);

        do_write(3'd0, 16'hF0CF);
        do_write(3'd1, 16'h0005);
        do_write(3'd2, 16'h8001);

        vecs[0] = '{3'd1, 3'd0, 2'd3, 0, 0, 3'd0, 16'h0000, 16'h0005, 16'hF0CF};
        vecs[1] = '{3'd1, 3'd0, 2'd3, 4, 0, 3'd0, 16'h0000, 16'h0005, 16'hF0CF};
        vecs[2] = '{3'd1, 3'd0, 2'd2, 0, 2, 3'd0, 16'h1234, 16'h0005, 16'h1234};
        vecs[3] = '{3'd1, 3'd0, 2'd1, 1, 2, 3'd1, 16'hAAAA, 16'h0005, 16'h1234};
        vecs[4] = '{3'd2, 3'd2, 2'd0, 0, 0, 3'd0, 16'h0000, 16'h8001, 16'h8001};
        vecs[5] = '{3'd2, 3'd2, 2'd1, 0, 1, 3'd2, 16'h7777, 16'h7777, 16'h7777};
        vecs[6] = '{3'd1, 3'd1, 2'd2, 3, 3, 3'd1, 16'h5555, 16'hAAAA, 16'hAAAA};
        vecs[7] = '{3'd3, 3'd4, 2'd3, 0, 1, 3'd4, 16'h00FF, 16'h0000, 16'h00FF};
        vecs[8] = '{3'd7, 3'd6, 2'd0, 2, 2, 3'd5, 16'h0BAD, 16'h0000, 16'h0000};

        for (int i = 0; i < 9; i++) begin
            fetch(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in READ_B, with a write and a request on the same edge.
        req_valid = 1'b1; rn = 3'd1; rm = 3'd0; shift_in = 2'd3;
        step();
        req_valid = 1'b0;
        step();
        reset = 1'b1; write = 1'b1; writenum = 3'd3; data_in = 16'hBEEF;
        req_valid = 1'b1;
        step();
        reset = 1'b0; write = 1'b0; req_valid = 1'b0;
        check("abort req_ready", 34'(req_ready), 34'd1);
        check("abort out_valid", 34'(out_valid), 34'd0);
        check("abort ain", 34'(ain), 34'd0);
        check("abort bin", 34'(bin), 34'd0);
        check("abort shift", 34'(shift), 34'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("abort out_valid quiet", 34'(out_valid), 34'd0);
        end
        for (int i = 0; i < 4; i++) begin
            vec_t z;
            z = '{3'(i), 3'(7 - i), 2'd0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
            fetch(z, $sformatf("cleared%0d", i));
        end

        // Randomized traffic against the reference model.
        busy = 1'b0; n = 0; crn = '0; crm = '0; csh = '0; ca = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            exp_ov = busy && (n == 2);
            check("rnd req_ready", 34'(req_ready), 34'(!busy));
            check("rnd out_valid", 34'(out_valid), 34'(exp_ov));
            if (exp_ov) begin
                if (exp_q.size() == 0) begin
                    check("rnd scoreboard empty", 34'(1), 34'(0));
                end else begin
                    check("rnd bundle", {ain, bin, shift}, exp_q[0]);
                end
            end
            reset     = ($urandom_range(0, 63) == 0);
            write     = 1'($urandom_range(0, 1));
            writenum  = 3'($urandom_range(0, 7));
            data_in   = 16'($urandom_range(0, 65535));
            req_valid = ($urandom_range(0, 2) != 0);
            rn        = 3'($urandom_range(0, 7));
            rm        = 3'($urandom_range(0, 7));
            shift_in  = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) == 0);
            step();
            if (reset) begin
                busy = 1'b0;
                exp_q.delete();
            end else if (!busy) begin
                if (req_valid) begin
                    busy = 1'b1; n = 0; crn = rn; crm = rm; csh = shift_in;
                end
            end else if (n == 0) begin
                ca = model_regs[crn];
                n = 1;
            end else if (n == 1) begin
                exp_q.push_back({ca, model_regs[crm], csh});
                n = 2;
            end else if (out_ready) begin
                void'(exp_q.pop_front());
                busy = 1'b0;
            end
        end
        reset = 1'b0; write = 1'b0; req_valid = 1'b0; out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
